ior_seq_ctrl: RTL and testbench
===============================

Name: ior_seq_ctrl

Overview:
- Sequencer for one I/O-registered prefix-adder tile: input slice register → precharged Brent-Kung prefix adder → output register.
- Per job it loads the input register slice by slice over a valid/ready stream, runs the precharge and evaluate phases of the adder, then drains the output register over a valid/ready stream.
- Sits between the tile and the system-level job dispatcher; owns every enable and phase strobe of the tile.

Parameters:
- SIZE, 16, tile width in bytes-equivalent (input register is 8*SIZE bits).
- INWIDTH, 16, input slice width; NSLICE = SIZE*8/INWIDTH input beats per job.
- OUTWIDTH, 16, output word width; OUT_BEATS = SIZE output beats per job.
- PRE_CYCLES, 1, precharge phase length in cycles (≥1).
- EVAL_CYCLES, 2, evaluate phase length in cycles (≥1).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  job request, sampled in IDLE only.
- busy  output  1  high from accepted start until done pulse inclusive.
- done  output  1  one-cycle pulse after last output beat.
- in_valid  input  1  upstream slice data valid.
- in_ready  output  1  controller accepts a slice this cycle.
- en_in  output  NSLICE  one-hot slice write enable to input register.
- in_clk_en  output  1  input-register clock enable, high on every accepted slice.
- pre_en  output  1  adder precharge phase strobe.
- eval_en  output  1  adder evaluate phase strobe.
- out_valid  output  1  output register word available.
- out_ready  input  1  downstream accepts output word.
- en_out  output  1  output-register shift enable.
- out_last  output  1  qualifies the final output beat.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all counters 0; every output 0. Release is synchronous to clk.
- FSM states: IDLE, LOAD, PRECH, EVAL, DRAIN, FIN.
- IDLE:
  - start=1 → LOAD next cycle; busy rises with that transition.
  - start while busy is ignored; no queuing.
- LOAD:
  - in_ready=1.
  - Beat accepted when in_valid&in_ready. That cycle: en_in=one-hot(slice_cnt), in_clk_en=1, slice_cnt++.
  - No beat accepted → en_in=0, in_clk_en=0.
  - Accepting beat NSLICE-1 → PRECH next cycle; slice_cnt returns to 0.
- PRECH:
  - pre_en=1 for exactly PRE_CYCLES cycles; in_ready=0.
  - Then EVAL.
  - pre_en and eval_en are never high in the same cycle, and never in consecutive cycles without an intervening state change.
- EVAL:
  - eval_en=1 for exactly EVAL_CYCLES cycles.
  - Then DRAIN. Adder result is valid on entry to DRAIN.
- DRAIN:
  - out_valid=1; en_out = out_valid&out_ready (combinational).
  - beat_cnt++ per accepted beat; out_last=1 while beat_cnt==OUT_BEATS-1.
  - Last beat accepted → FIN. Stalls (out_ready=0) are unbounded with no timeout; en_out stays 0 during a stall.
- FIN: done=1 and busy=1 for one cycle, then IDLE, busy=0. A start in FIN is ignored; start is accepted from the following IDLE cycle.
- Latency, no stalls: start → first in_ready = 1 cycle. Job length = 1 + NSLICE + PRE_CYCLES + EVAL_CYCLES + OUT_BEATS + 1 cycles. Defaults: 1+8+1+2+16+1 = 29.
- Counters are $clog2-sized, minimum 1 bit. They never wrap within a job, and every counter reset to 0 on state exit.
- Reset asserted mid-job aborts immediately. No done pulse; tile contents are undefined and not cleaned.
- Outputs are registered except in_clk_en, en_in and en_out, which are combinational from state plus handshake inputs.

Optional Feature:
- Macro IOR_SEQ_PERF_CNT_EN.
- Defined:
  - Adds output port stall_cnt (16 bits): count of DRAIN cycles with out_ready=0 plus LOAD cycles with in_valid=0 in the current job.
  - Cleared on accepted start, frozen from FIN until the next start, saturates at 16'hFFFF, and resets to 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package ior_pkg holds:
  - state enum ior_seq_state_t (IDLE..FIN);
  - derived-width functions NSLICE(SIZE,INWIDTH) and the bussize constant SIZE+16;
  - the default phase lengths.
- One natural sub-module: ior_phase_timer, a loadable down-counter with a zero flag, used for both PRECH and EVAL.

Test Plan:
- Reset mid-DRAIN (beat 5): assert rst_n=0 → next cycle every output 0, state IDLE, no done pulse; fresh job then completes normally.
- Nominal job, defaults, in_valid/out_ready held high, start at cycle 0 →
  - en_in walks 0x01..0x80 over cycles 1–8;
  - pre_en at cycle 9; eval_en at cycles 10–11;
  - out_valid at cycles 12–27 with out_last at 27;
  - done at 28.
- Input bubbles: in_valid low on alternate cycles → exactly 8 in_clk_en pulses, en_in never repeats an index, PRECH entered one cycle after the 8th accept.
- Output backpressure: out_ready low for 10 cycles at beat 3 → en_out=0 throughout the stall, beat_cnt holds at 3, total en_out pulses = 16, out_last coincides with the 16th pulse only.
- start pulses during busy and in the FIN cycle → ignored; exactly one job runs; a start in the following IDLE cycle begins job 2.
- With IOR_SEQ_PERF_CNT_EN: 3 input bubbles and 10 output-stall cycles → stall_cnt=13 at done, held until next start, then cleared to 0.

Source files
------------

// File: rtl/ior_pkg.sv
// Shared types and sizing helpers for the I/O-registered prefix-adder tile sequencer.
package ior_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PRECH,
    EVAL,
    DRAIN,
    FIN
  } ior_seq_state_t;

  localparam int DEF_SIZE        = 16;
  localparam int DEF_INWIDTH     = 16;
  localparam int DEF_OUTWIDTH    = 16;
  localparam int DEF_PRE_CYCLES  = 1;
  localparam int DEF_EVAL_CYCLES = 2;

  function automatic int calc_nslice(input int size, input int inwidth);
    return (size * 8) / inwidth;
  endfunction

  function automatic int bussize(input int size);
    return size + 16;
  endfunction

  // Bits needed to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ior_phase_timer.sv
// Loadable down-counter with zero flag; times both the precharge and evaluate phases.
module ior_phase_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/ior_seq_ctrl.sv
// Job sequencer for the prefix-adder tile: load slices, precharge, evaluate, drain.
// Optional stall counter port is enabled with `define IOR_SEQ_PERF_CNT_EN.
module ior_seq_ctrl
  import ior_pkg::*;
#(
  parameter int SIZE        = DEF_SIZE,
  parameter int INWIDTH     = DEF_INWIDTH,
  parameter int OUTWIDTH    = DEF_OUTWIDTH,
  parameter int PRE_CYCLES  = DEF_PRE_CYCLES,
  parameter int EVAL_CYCLES = DEF_EVAL_CYCLES
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  output logic                                   busy,
  output logic                                   done,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic [calc_nslice(SIZE, INWIDTH)-1:0]  en_in,
  output logic                                   in_clk_en,
  output logic                                   pre_en,
  output logic                                   eval_en,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   en_out,
  output logic                                   out_last
`ifdef IOR_SEQ_PERF_CNT_EN
  ,
  output logic [15:0]                            stall_cnt
`endif
);

  localparam int NSLICE    = calc_nslice(SIZE, INWIDTH);
  localparam int OUT_BEATS = SIZE;
  localparam int SLICE_W   = cnt_width(NSLICE);
  localparam int BEAT_W    = cnt_width(OUT_BEATS);
  localparam int TMR_W     = cnt_width((PRE_CYCLES > EVAL_CYCLES) ? PRE_CYCLES : EVAL_CYCLES);

  if (OUTWIDTH < 1 || PRE_CYCLES < 1 || EVAL_CYCLES < 1 || ((SIZE * 8) % INWIDTH) != 0) begin : g_cfg_err
    $error("ior_seq_ctrl: invalid parameter set");
  end

  ior_seq_state_t     state_q, state_d;
  logic [SLICE_W-1:0] sliceCnt_q, sliceCnt_d;
  logic [BEAT_W-1:0]  beatCnt_q, beatCnt_d;
  logic               tmrLoad;
  logic [TMR_W-1:0]   tmrLoadVal;
  logic               tmrDec;
  logic               tmrZero;
  logic               inAccept;
  logic               outAccept;

  assign inAccept  = (state_q == LOAD) && in_valid;
  assign outAccept = (state_q == DRAIN) && out_ready;

  ior_phase_timer #(
    .W (TMR_W)
  ) u_phase_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmrLoad),
    .load_val_i (tmrLoadVal),
    .dec_i      (tmrDec),
    .zero_o     (tmrZero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sliceCnt_q <= '0;
      beatCnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      sliceCnt_q <= sliceCnt_d;
      beatCnt_q  <= beatCnt_d;
    end
  end

  // The phase timer is loaded on the edge into each phase, so it reads zero on the phase's last cycle.
  always_comb begin
    state_d    = state_q;
    sliceCnt_d = sliceCnt_q;
    beatCnt_d  = beatCnt_q;
    tmrLoad    = 1'b0;
    tmrLoadVal = '0;
    tmrDec     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        if (in_valid) begin
          if (sliceCnt_q == SLICE_W'(NSLICE - 1)) begin
            sliceCnt_d = '0;
            state_d    = PRECH;
            tmrLoad    = 1'b1;
            tmrLoadVal = TMR_W'(PRE_CYCLES - 1);
          end else begin
            sliceCnt_d = sliceCnt_q + 1'b1;
          end
        end
      end
      PRECH: begin
        if (tmrZero) begin
          state_d    = EVAL;
          tmrLoad    = 1'b1;
          tmrLoadVal = TMR_W'(EVAL_CYCLES - 1);
        end else begin
          tmrDec = 1'b1;
        end
      end
      EVAL: begin
        if (tmrZero) state_d = DRAIN;
        else         tmrDec  = 1'b1;
      end
      DRAIN: begin
        if (out_ready) begin
          if (beatCnt_q == BEAT_W'(OUT_BEATS - 1)) begin
            beatCnt_d = '0;
            state_d   = FIN;
          end else begin
            beatCnt_d = beatCnt_q + 1'b1;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign in_ready  = (state_q == LOAD);
  assign pre_en    = (state_q == PRECH);
  assign eval_en   = (state_q == EVAL);
  assign out_valid = (state_q == DRAIN);
  assign out_last  = (state_q == DRAIN) && (beatCnt_q == BEAT_W'(OUT_BEATS - 1));
  assign in_clk_en = inAccept;
  assign en_in     = inAccept ? (NSLICE'(1) << sliceCnt_q) : '0;
  assign en_out    = outAccept;

`ifdef IOR_SEQ_PERF_CNT_EN
  logic [15:0] stallCnt_q;

  // Cleared when a job is accepted; only LOAD/DRAIN stalls advance it, so it freezes from FIN onward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      stallCnt_q <= '0;
    end else if (((state_q == LOAD) && !in_valid) || ((state_q == DRAIN) && !out_ready)) begin
      if (stallCnt_q != 16'hFFFF) stallCnt_q <= stallCnt_q + 16'd1;
    end
  end

  assign stall_cnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_ior_seq_ctrl.sv
// Directed bench for ior_seq_ctrl: cycle table for a nominal job plus multi-cycle corner sequences.
module tb_ior_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic       out_ready;
  logic       busy, done, in_ready, in_clk_en, pre_en, eval_en, out_valid, en_out, out_last;
  logic [7:0] en_in;
`ifdef IOR_SEQ_PERF_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       start;
    logic       inValid;
    logic       outReady;
    logic [8:0] expWord;
    logic [7:0] expEnIn;
  } vec_t;

  vec_t vecs[30];

  always #5 clk = ~clk;

  ior_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .en_in     (en_in),
    .in_clk_en (in_clk_en),
    .pre_en    (pre_en),
    .eval_en   (eval_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .en_out    (en_out),
    .out_last  (out_last)
`ifdef IOR_SEQ_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  function automatic logic [8:0] mkWord(input logic b, input logic d, input logic ir, input logic ce,
                                        input logic pr, input logic ev, input logic ov, input logic eo,
                                        input logic ls);
    return {b, d, ir, ce, pr, ev, ov, eo, ls};
  endfunction

  function automatic logic [8:0] outWord();
    return {busy, done, in_ready, in_clk_en, pre_en, eval_en, out_valid, en_out, out_last};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    start     = v.start;
    in_valid  = v.inValid;
    out_ready = v.outReady;
  endtask

  // Expected per-cycle outputs of an unstalled default job started at cycle 0.
  task automatic buildTable();
    for (int c = 0; c < 30; c++) begin
      vecs[c].start    = (c == 0);
      vecs[c].inValid  = 1'b1;
      vecs[c].outReady = 1'b1;
      vecs[c].expEnIn  = 8'h00;
      if (c >= 1 && c <= 8) begin
        vecs[c].expWord = mkWord(1, 0, 1, 1, 0, 0, 0, 0, 0);
        vecs[c].expEnIn = 8'h01 << (c - 1);
      end else if (c == 9) begin
        vecs[c].expWord = mkWord(1, 0, 0, 0, 1, 0, 0, 0, 0);
      end else if (c == 10 || c == 11) begin
        vecs[c].expWord = mkWord(1, 0, 0, 0, 0, 1, 0, 0, 0);
      end else if (c >= 12 && c <= 27) begin
        vecs[c].expWord = mkWord(1, 0, 0, 0, 0, 0, 1, 1, (c == 27));
      end else if (c == 28) begin
        vecs[c].expWord = mkWord(1, 1, 0, 0, 0, 0, 0, 0, 0);
      end else begin
        vecs[c].expWord = 9'h000;
      end
    end
  endtask

  task automatic runTable(input string tag);
    for (int i = 0; i < 30; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("%s_c%0d_word", tag, i), 32'(outWord()), 32'(vecs[i].expWord));
      checkOutput($sformatf("%s_c%0d_en_in", tag, i), 32'(en_in), 32'(vecs[i].expEnIn));
      @(posedge clk);
      #1;
    end
  endtask

  // One job with nBubbles alternating input gaps and a stallLen-cycle output stall after stallBeat beats.
  task automatic runJob(input string tag, input int nBubbles, input int stallBeat, input int stallLen,
                        input bit spam);
    int inPulses = 0, outPulses = 0, doneCnt = 0;
    int enInErr = 0, stallErr = 0, lastErr = 0;
    int acc8Cyc = -1, preCyc = -1, doneCyc = -1;
    int bubLeft = nBubbles, stallLeft = stallLen;
    bit phase = 1'b0;
    logic [7:0] seen = 8'h00;
    logic [15:0] stallAtDone = 16'h0000;
    for (int cyc = 0; cyc < 300; cyc++) begin
      start = (cyc == 0) ? 1'b1 : (spam ? busy : 1'b0);
      if (in_ready) begin
        if (bubLeft > 0 && phase) begin
          in_valid = 1'b0;
          bubLeft--;
          phase = 1'b0;
        end else begin
          in_valid = 1'b1;
          phase = 1'b1;
        end
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid && outPulses == stallBeat && stallLeft > 0) begin
        out_ready = 1'b0;
        stallLeft--;
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (in_clk_en) begin
        inPulses++;
        if (!$onehot(en_in) || (seen & en_in) != 8'h00) enInErr++;
        seen |= en_in;
        if (inPulses == 8) acc8Cyc = cyc;
      end else if (en_in != 8'h00) begin
        enInErr++;
      end
      if (pre_en && preCyc < 0) preCyc = cyc;
      if (!out_ready && en_out) stallErr++;
      if (en_out) outPulses++;
      if (out_last != (en_out && outPulses == 16)) lastErr++;
      if (done) begin
        doneCnt++;
        doneCyc = cyc;
`ifdef IOR_SEQ_PERF_CNT_EN
        stallAtDone = stall_cnt;
`endif
      end
      @(posedge clk);
      #1;
      if (doneCyc >= 0) break;
    end
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput({tag, "_done_seen"}, 32'(doneCyc >= 0), 32'd1);
    checkOutput({tag, "_in_pulses"}, 32'(inPulses), 32'd8);
    checkOutput({tag, "_en_in_err"}, 32'(enInErr), 32'd0);
    checkOutput({tag, "_prech_after_8th"}, 32'(preCyc), 32'(acc8Cyc + 1));
    checkOutput({tag, "_stall_en_out"}, 32'(stallErr), 32'd0);
    checkOutput({tag, "_out_pulses"}, 32'(outPulses), 32'd16);
    checkOutput({tag, "_out_last_err"}, 32'(lastErr), 32'd0);
    checkOutput({tag, "_done_count"}, 32'(doneCnt), 32'd1);
    checkOutput({tag, "_job_len"}, 32'(doneCyc), 32'(28 + nBubbles + stallLen));
`ifdef IOR_SEQ_PERF_CNT_EN
    checkOutput({tag, "_stall_cnt"}, 32'(stallAtDone), 32'(nBubbles + stallLen));
`else
    stallAtDone = 16'h0000;
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    buildTable();
    repeat (2) @(negedge clk);
    checkOutput("reset_word", 32'(outWord()), 32'd0);
    checkOutput("reset_en_in", 32'(en_in), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] nominal job");
    runTable("nom");

    $display("[TB] reset during drain beat 5");
    start     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (16) begin
      @(posedge clk);
      #1;
    end
    checkOutput("pre_reset_drain", 32'(outWord()), 32'(mkWord(1, 0, 0, 0, 0, 0, 1, 1, 0)));
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_word", 32'(outWord()), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("mid_reset_hold%0d", i), 32'(outWord()), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    runTable("post_reset");

    $display("[TB] input bubbles");
    runJob("bubbles", 7, 0, 0, 1'b0);

    $display("[TB] output backpressure");
    runJob("backpressure", 0, 3, 10, 1'b0);

    $display("[TB] start spam during busy and FIN");
    runJob("spam", 0, 0, 0, 1'b1);
    checkOutput("idle_after_fin_busy", 32'(busy), 32'd0);
    runJob("job2", 3, 3, 10, 1'b0);

`ifdef IOR_SEQ_PERF_CNT_EN
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("stall_hold%0d", i), 32'(stall_cnt), 32'd13);
    end
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("stall_cleared", 32'(stall_cnt), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
